// File: rtl/sid_bus_pkg.sv
// Shared definitions for the SID host bus: field positions, register map,
// sequencer state encoding and the queued command payload.
package sid_bus_pkg;

    localparam int unsigned STROBE_BIT  = 7;
    localparam int unsigned VOICE_LSB   = 3;
    localparam int unsigned ADDR_LSB    = 0;
    localparam int unsigned VOICE_W     = 2;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CMD_DELAY_W = 24;

    // Per-voice register map
    localparam logic [ADDR_W-1:0] REG_FREQ_LO = 3'd0;
    localparam logic [ADDR_W-1:0] REG_FREQ_HI = 3'd1;
    localparam logic [ADDR_W-1:0] REG_PW_LO   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_PW_HI   = 3'd3;
    localparam logic [ADDR_W-1:0] REG_ATK     = 3'd4;
    localparam logic [ADDR_W-1:0] REG_SUS     = 3'd5;
    localparam logic [ADDR_W-1:0] REG_WAV     = 3'd6;

    // Filter/volume bank, selected with VOICE_FILT
    localparam logic [ADDR_W-1:0] REG_FC_LO    = 3'd0;
    localparam logic [ADDR_W-1:0] REG_FC_HI    = 3'd1;
    localparam logic [ADDR_W-1:0] REG_RES_FILT = 3'd2;
    localparam logic [ADDR_W-1:0] REG_MODE_VOL = 3'd3;

    localparam logic [VOICE_W-1:0] VOICE_FILT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_WAIT
    } seq_state_e;

    typedef struct packed {
        logic [VOICE_W-1:0]     voice;
        logic [ADDR_W-1:0]      addr;
        logic [DATA_W-1:0]      data;
        logic [CMD_DELAY_W-1:0] delay;
    } sid_cmd_t;

    function automatic logic [7:0] bus_ctrl_word(input logic               strobe,
                                                 input logic [VOICE_W-1:0] voice,
                                                 input logic [ADDR_W-1:0]  addr);
        logic [7:0] w;
        w                        = '0;
        w[STROBE_BIT]            = strobe;
        w[VOICE_LSB +: VOICE_W]  = voice;
        w[ADDR_LSB  +: ADDR_W]   = addr;
        return w;
    endfunction

endpackage

// File: rtl/sid_reg_sequencer_if.sv
// Command channel into the register sequencer: valid/ready plus the write fields.
interface sid_reg_sequencer_if #(
    parameter int unsigned DELAY_W = 24
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_voice;
    logic [2:0]         cmd_addr;
    logic [7:0]         cmd_data;
    logic [DELAY_W-1:0] cmd_delay;

    modport master (
        output cmd_valid, cmd_voice, cmd_addr, cmd_data, cmd_delay,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_voice, cmd_addr, cmd_data, cmd_delay,
        output cmd_ready
    );
endinterface

// File: rtl/sid_cmd_fifo.sv
// Synchronous command queue; the head entry is read straight from the storage
// registers and ready is a registered !full that stays low during reset.
module sid_cmd_fifo
    import sid_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  sid_cmd_t wdata,
    input  logic     pop,
    output sid_cmd_t head,
    output logic     empty,
    output logic     empty_nxt_c,
    output logic     ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    sid_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            do_push;
    logic            do_pop;

    assign do_push     = push && ready;
    assign do_pop      = pop && (count != '0);
    assign count_n     = count + CW'(do_push) - CW'(do_pop);
    assign empty       = (count == '0);
    assign empty_nxt_c = (count_n == '0);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            ready <= (count_n != CW'(DEPTH));
        end
    end
endmodule

// File: rtl/sid_reg_sequencer.sv
// Replays queued SID register writes as setup / strobe / hold bus cycles,
// followed by an optional per-command idle gap.
module sid_reg_sequencer
    import sid_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DELAY_W    = 24,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sid_reg_sequencer_if.slave  cmd,
    output logic [7:0]          bus_ctrl,
    output logic [7:0]          bus_data,
    output logic                busy,
    output logic [15:0]         writes_done
);
    localparam int unsigned PH_W = 16;

    seq_state_e         state, state_n;
    logic [PH_W-1:0]    phase_cnt, phase_n;
    logic [DELAY_W-1:0] wait_cnt, wait_n;
    logic [7:0]         ctrl_n;
    logic [7:0]         data_n;
    logic               busy_n;
    logic [15:0]        done_n;

    sid_cmd_t           push_cmd;
    sid_cmd_t           head;
    logic               fifo_empty;
    logic               fifo_empty_nxt_c;
    logic               fifo_ready;
    logic               pop_c;

    assign push_cmd = '{voice: cmd.cmd_voice,
                        addr:  cmd.cmd_addr,
                        data:  cmd.cmd_data,
                        delay: CMD_DELAY_W'(cmd.cmd_delay)};
    assign cmd.cmd_ready = fifo_ready;

    sid_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (cmd.cmd_valid),
        .wdata       (push_cmd),
        .pop         (pop_c),
        .head        (head),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt_c),
        .ready       (fifo_ready)
    );

    // Next state and next registered bus values; the bus fields move only on pop.
    always_comb begin
        state_n   = state;
        phase_n   = phase_cnt;
        wait_n    = wait_cnt;
        ctrl_n    = bus_ctrl;
        data_n    = bus_data;
        done_n    = writes_done;
        pop_c     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    state_n = ST_SETUP;
                    phase_n = PH_W'(SETUP_CYC - 1);
                    wait_n  = DELAY_W'(head.delay);
                    ctrl_n  = bus_ctrl_word(1'b0, head.voice, head.addr);
                    data_n  = head.data;
                end
            end
            ST_SETUP: begin
                if (phase_cnt == '0) begin
                    state_n            = ST_STROBE;
                    phase_n            = PH_W'(STROBE_CYC - 1);
                    ctrl_n[STROBE_BIT] = 1'b1;
                end else begin
                    phase_n = phase_cnt - PH_W'(1);
                end
            end
            ST_STROBE: begin
                if (phase_cnt == '0) begin
                    state_n            = ST_HOLD;
                    phase_n            = PH_W'(HOLD_CYC - 1);
                    ctrl_n[STROBE_BIT] = 1'b0;
                    done_n             = writes_done + 16'd1;
                end else begin
                    phase_n = phase_cnt - PH_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_cnt == '0) begin
                    state_n = (wait_cnt != '0) ? ST_WAIT : ST_IDLE;
                end else begin
                    phase_n = phase_cnt - PH_W'(1);
                end
            end
            ST_WAIT: begin
                wait_n = wait_cnt - DELAY_W'(1);
                if (wait_cnt <= DELAY_W'(1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE) || !fifo_empty_nxt_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            wait_cnt    <= '0;
            bus_ctrl    <= '0;
            bus_data    <= '0;
            busy        <= 1'b0;
            writes_done <= '0;
        end else begin
            state       <= state_n;
            phase_cnt   <= phase_n;
            wait_cnt    <= wait_n;
            bus_ctrl    <= ctrl_n;
            bus_data    <= data_n;
            busy        <= busy_n;
            writes_done <= done_n;
        end
    end
endmodule

// File: tb/tb_sid_reg_sequencer.sv
// Bench for sid_reg_sequencer: directed write table, burst/delay/reset
// sequences and randomized traffic checked against a timeline model.
module tb_sid_reg_sequencer;
    import sid_bus_pkg::*;

    localparam int SETUP  = 1;
    localparam int STROBE = 2;
    localparam int HOLD   = 1;
    localparam int DEPTH  = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bus_ctrl;
    logic [7:0]  bus_data;
    logic        busy;
    logic [15:0] writes_done;

    sid_reg_sequencer_if #(.DELAY_W(24)) cif ();

    sid_reg_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .DELAY_W    (24),
        .SETUP_CYC  (SETUP),
        .STROBE_CYC (STROBE),
        .HOLD_CYC   (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cif),
        .bus_ctrl    (bus_ctrl),
        .bus_data    (bus_data),
        .busy        (busy),
        .writes_done (writes_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic rst_q  = 1'b0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst_n;
    end

    // Timeline model: each accepted write gets its strobe-rise cycle from
    // max(push + 2 + SETUP, previous rise + STROBE + HOLD + delay + 1 + SETUP).
    typedef struct {
        logic [1:0] voice;
        logic [2:0] addr;
        logic [7:0] data;
        int         delay;
        int         rise;
    } wr_t;

    wr_t         hist[$];
    int          rise_log[$];
    int          next_obs = 0;
    int          hi_cnt   = 0;
    logic        prev_stb = 1'b0;
    logic [15:0] model_wd = '0;

    always @(negedge clk) begin
        int   occ;
        logic win;
        wr_t  e;
        int   r;
        int   s;
        if (cyc > 0) begin
            if (!rst_q) begin
                chk("rst_bus_ctrl", bus_ctrl, 0);
                chk("rst_bus_data", bus_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_writes_done", writes_done, 0);
                chk("rst_cmd_ready", cif.cmd_ready, 0);
                hist.delete();
                next_obs = 0;
                hi_cnt   = 0;
                prev_stb = 1'b0;
                model_wd = '0;
            end else begin
                occ = 0;
                win = 1'b0;
                foreach (hist[i]) begin
                    if (hist[i].rise - 2 >= cyc) occ++;
                    if (cyc >= hist[i].rise - SETUP &&
                        cyc <= hist[i].rise + STROBE + HOLD - 1 + hist[i].delay) win = 1'b1;
                end
                chk("cmd_ready", cif.cmd_ready, (occ < DEPTH) ? 1 : 0);
                chk("busy", busy, (occ > 0 || win) ? 1 : 0);
                if (bus_ctrl[7] && !prev_stb) begin
                    rise_log.push_back(cyc);
                    if (next_obs < hist.size()) begin
                        e = hist[next_obs];
                        next_obs++;
                        chk("rise_cycle", cyc, e.rise);
                        chk("strobe_ctrl", bus_ctrl, {1'b1, 2'b00, e.voice, e.addr});
                        chk("strobe_data", bus_data, e.data);
                    end else begin
                        chk("unexpected_strobe", 1, 0);
                    end
                    hi_cnt = 1;
                end else if (bus_ctrl[7]) begin
                    hi_cnt++;
                end else if (prev_stb) begin
                    chk("strobe_width", hi_cnt, STROBE);
                    model_wd = model_wd + 16'd1;
                    chk("writes_done", writes_done, model_wd);
                end
                prev_stb = bus_ctrl[7];
            end
            if (rst_n && cif.cmd_valid && cif.cmd_ready) begin
                r = cyc + 2 + SETUP;
                if (hist.size() > 0) begin
                    s = hist[$].rise + STROBE + HOLD + hist[$].delay + 1 + SETUP;
                    if (s > r) r = s;
                end
                hist.push_back('{voice: cif.cmd_voice, addr: cif.cmd_addr,
                                 data: cif.cmd_data, delay: int'(cif.cmd_delay), rise: r});
            end
        end
    end

    task automatic send(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                        input int dl, output int pc);
        int n;
        n = 0;
        cif.cmd_voice = v;
        cif.cmd_addr  = a;
        cif.cmd_data  = d;
        cif.cmd_delay = 24'(dl);
        cif.cmd_valid = 1'b1;
        @(negedge clk);
        while (!cif.cmd_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) chk("send_timeout", 1, 0);
        pc = cyc;
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  voice;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [7:0]  exp_setup;
        logic [7:0]  exp_strobe;
        logic [15:0] exp_wd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int pc;
        int base;
        vecs[0] = '{2'd0, REG_WAV,      8'h21, 8'h06, 8'h86, 16'd1};
        vecs[1] = '{VOICE_FILT, REG_MODE_VOL, 8'h0F, 8'h1B, 8'h9B, 16'd2};
        vecs[2] = '{2'd1, REG_FREQ_LO,  8'hAA, 8'h08, 8'h88, 16'd3};
        vecs[3] = '{2'd2, REG_SUS,      8'h55, 8'h15, 8'h95, 16'd4};
        vecs[4] = '{2'd3, 3'd7,         8'hFF, 8'h1F, 8'h9F, 16'd5};

        rst_n         = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_voice = '0;
        cif.cmd_addr  = '0;
        cif.cmd_data  = '0;
        cif.cmd_delay = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single writes: exact per-cycle bus shape
        for (int i = 0; i < 5; i++) begin
            wait_idle(100);
            send(vecs[i].voice, vecs[i].addr, vecs[i].data, 0, pc);
            wait_neg(pc + 2);
            chk("setup_ctrl", bus_ctrl, vecs[i].exp_setup);
            chk("setup_data", bus_data, vecs[i].data);
            wait_neg(pc + 3);
            chk("strobe1_ctrl", bus_ctrl, vecs[i].exp_strobe);
            wait_neg(pc + 4);
            chk("strobe2_ctrl", bus_ctrl, vecs[i].exp_strobe);
            chk("strobe2_data", bus_data, vecs[i].data);
            wait_neg(pc + 5);
            chk("hold_ctrl", bus_ctrl, vecs[i].exp_setup);
            chk("hold_writes_done", writes_done, vecs[i].exp_wd);
            wait_neg(pc + 6);
            chk("idle_ctrl", bus_ctrl, vecs[i].exp_setup);
            chk("idle_data", bus_data, vecs[i].data);
            chk("idle_busy", busy, 0);
            @(posedge clk);
            #1;
        end

        // Back-to-back burst overrunning the queue
        wait_idle(100);
        rise_log.delete();
        for (int i = 0; i < 6; i++) send(2'(i % 3), 3'(i), 8'(8'h40 + i), 0, pc);
        wait_idle(300);
        chk("burst_strobes", rise_log.size(), 6);
        for (int i = 1; i < rise_log.size(); i++) chk("burst_spacing", rise_log[i] - rise_log[i-1], 5);
        chk("burst_writes_done", writes_done, 11);

        // Long post-delay between two writes
        rise_log.delete();
        send(2'd0, REG_WAV, 8'h21, 1000, pc);
        send(2'd0, REG_WAV, 8'h20, 0, pc);
        wait_idle(3000);
        chk("delay_strobes", rise_log.size(), 2);
        if (rise_log.size() == 2) chk("delay_spacing", rise_log[1] - rise_log[0], 1005);
        chk("delay_writes_done", writes_done, 13);

        // Reset in the second strobe cycle discards everything
        send(2'd1, REG_ATK, 8'h7B, 0, pc);
        send(2'd1, REG_SUS, 8'hB8, 0, pc);
        send(2'd1, REG_WAV, 8'h41, 0, pc);
        base = 0;
        @(negedge clk);
        while (!bus_ctrl[7] && base < 50) begin
            base++;
            @(negedge clk);
        end
        chk("reset_strobe_seen", bus_ctrl[7], 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_bus_ctrl", bus_ctrl, 0);
        chk("abort_bus_data", bus_data, 0);
        chk("abort_writes_done", writes_done, 0);
        chk("abort_busy", busy, 0);
        rise_log.delete();
        repeat (60) @(negedge clk);
        chk("no_strobe_after_reset", rise_log.size(), 0);
        @(posedge clk);
        #1;

        // Randomized traffic against the timeline model
        for (int i = 0; i < 40; i++) begin
            int gap;
            int dl;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom), dl, pc);
        end
        wait_idle(5000);
        chk("all_writes_seen", next_obs, hist.size());
        chk("random_writes_done", writes_done, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
